// File: rtl/safe_code_lock.sv
// Safe password FSM: BCD digits are dialled with INC, confirmed with NEXT, and the full
// entry is compared against the stored code. Repeated mismatches trigger a timed alarm lockout.
module safe_code_lock #(
    parameter int unsigned  DIGITS      = 4,
    parameter int unsigned  MAX_FAIL    = 3,
    parameter int unsigned  LOCK_CYCLES = 36000000,
    parameter int unsigned  TIMER_W     = 26,
    parameter logic [15:0]  INIT_CODE   = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_pulse,
    input  logic       next_pulse,
    input  logic       lock_pulse,
    output logic [3:0] cur_digit,
    output logic [1:0] cur_pos,
    output logic [1:0] fail_cnt,
    output logic       unlocked,
    output logic       alarm
);

    localparam logic [2:0] ST_ENTRY   = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_SETPW   = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam logic [1:0]         LAST_POS  = 2'(DIGITS - 1);
    localparam logic [1:0]         FAIL_MAX  = 2'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(LOCK_CYCLES - 1);

    logic [2:0]         state;
    logic [15:0]        entry;
    logic [15:0]        code;
    logic [TIMER_W-1:0] timer;

    logic        do_lock, do_next, do_inc;
    logic        last_pos, match;
    logic [3:0]  digit_inc;
    logic [1:0]  fail_inc;
    logic [15:0] entry_w;

    always_comb begin
        do_lock   = lock_pulse;
        do_next   = next_pulse & ~lock_pulse;
        do_inc    = inc_pulse & ~next_pulse & ~lock_pulse;
        digit_inc = (cur_digit >= 4'd9) ? '0 : cur_digit + 4'd1;
        last_pos  = (cur_pos == LAST_POS);
        fail_inc  = fail_cnt + 2'd1;
        // Entry buffer as it will look once the digit being confirmed is stored.
        entry_w   = entry;
        entry_w[{cur_pos, 2'b00} +: 4] = cur_digit;
        match = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < DIGITS && entry[i*4 +: 4] != code[i*4 +: 4]) begin
                match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_ENTRY;
            cur_digit <= '0;
            cur_pos   <= '0;
            fail_cnt  <= '0;
            entry     <= '0;
            code      <= INIT_CODE;
            timer     <= '0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (do_lock) begin
                        entry     <= '0;
                        cur_pos   <= '0;
                        cur_digit <= '0;
                    end else if (do_next) begin
                        entry     <= entry_w;
                        cur_digit <= '0;
                        if (last_pos) begin
                            cur_pos <= '0;
                            state   <= ST_CHECK;
                        end else begin
                            cur_pos <= cur_pos + 2'd1;
                        end
                    end else if (do_inc) begin
                        cur_digit <= digit_inc;
                    end
                end
                ST_CHECK: begin
                    entry <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                        unlocked <= 1'b1;
                        state    <= ST_OPEN;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                            alarm <= 1'b1;
                            timer <= '0;
                            state <= ST_LOCKOUT;
                        end else begin
                            state <= ST_ENTRY;
                        end
                    end
                end
                ST_OPEN: begin
                    if (do_lock) begin
                        unlocked <= 1'b0;
                        state    <= ST_ENTRY;
                    end else if (do_next) begin
                        cur_pos   <= '0;
                        cur_digit <= '0;
                        entry     <= '0;
                        state     <= ST_SETPW;
                    end
                end
                ST_SETPW: begin
                    if (do_lock) begin
                        entry     <= '0;
                        cur_pos   <= '0;
                        cur_digit <= '0;
                        state     <= ST_OPEN;
                    end else if (do_next) begin
                        cur_digit <= '0;
                        if (last_pos) begin
                            code    <= entry_w;
                            entry   <= '0;
                            cur_pos <= '0;
                            state   <= ST_OPEN;
                        end else begin
                            entry   <= entry_w;
                            cur_pos <= cur_pos + 2'd1;
                        end
                    end else if (do_inc) begin
                        cur_digit <= digit_inc;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer == TIMER_MAX) begin
                        timer    <= '0;
                        fail_cnt <= '0;
                        alarm    <= 1'b0;
                        state    <= ST_ENTRY;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    unlocked <= 1'b0;
                    alarm    <= 1'b0;
                    state    <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule
